// File: rtl/iob_regarray_sp_ctrl_pkg.sv
// Shared configuration for the single-port register-array controller: default
// geometry, FSM state and grant encodings.
package iob_regarray_sp_ctrl_pkg;

  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_INIT_VAL = 0;

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_IDLE = 1'b1;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef enum logic {
    ST_INIT = STATE_INIT,
    ST_IDLE = STATE_IDLE
  } state_t;

  // One-hot grant vector (bit 0 = A, bit 1 = B) for a grant index.
  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/iob_regarray_sp_rr_arb2.sv
// Two-input round-robin arbiter; owns the last-grant register and yields a
// one-hot grant (bit 0 = A, bit 1 = B).
module iob_regarray_sp_rr_arb2
  import iob_regarray_sp_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       cke_i,
  input  logic       arst_i,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic r_last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (&valid_i) begin
        grant_o = grant_onehot(~r_last_grant);
      end else begin
        grant_o = valid_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_last_grant <= GRANT_B;
    end else if (cke_i && accept_i) begin
      r_last_grant <= grant_o[1] ? GRANT_B : GRANT_A;
    end
  end

endmodule

// File: rtl/iob_regarray_sp_ctrl.sv
// Shares one single-port register array between requesters A and B.
// Define IOB_REGARRAY_SP_CTRL_INIT_EN to add a post-reset INIT_VAL clear sweep.
module iob_regarray_sp_ctrl
  import iob_regarray_sp_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = DEF_ADDR_W,
  parameter int                 DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0]  INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              arr_we_o,
  output logic [ADDR_W-1:0] arr_addr_o,
  output logic [DATA_W-1:0] arr_d_o,
  input  logic [DATA_W-1:0] arr_d_i,
  output logic              init_done_o
);

  logic              w_idle;
  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_d;
  logic [1:0]        w_grant;
  logic              w_hs_a;
  logic              w_hs_b;
  logic              w_rd_a;
  logic              w_rd_b;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  assign w_init_d = INIT_VAL;

`ifdef IOB_REGARRAY_SP_CTRL_INIT_EN
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else if (cke_i) begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_next = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign w_init_we   = ~w_idle & cke_i;
  assign w_init_addr = r_cnt;
`else
  assign w_idle      = 1'b1;
  assign w_init_we   = 1'b0;
  assign w_init_addr = '0;
`endif

  iob_regarray_sp_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .arst_i   (arst_i),
    .valid_i  ({b_valid_i, a_valid_i}),
    .en_i     (w_idle & cke_i),
    .accept_i (w_hs_a | w_hs_b),
    .grant_o  (w_grant)
  );

  assign a_ready_o = w_grant[0];
  assign b_ready_o = w_grant[1];
  assign w_hs_a    = a_valid_i & a_ready_o;
  assign w_hs_b    = b_valid_i & b_ready_o;
  assign w_rd_a    = w_hs_a & ~a_we_i;
  assign w_rd_b    = w_hs_b & ~b_we_i;

  // A's payload sits on the array bus whenever B is not granted.
  always_comb begin
    arr_we_o   = 1'b0;
    arr_addr_o = a_addr_i;
    arr_d_o    = a_wdata_i;
    if (!w_idle) begin
      arr_we_o   = w_init_we;
      arr_addr_o = w_init_addr;
      arr_d_o    = w_init_d;
    end else begin
      if (w_grant[1]) begin
        arr_addr_o = b_addr_i;
        arr_d_o    = b_wdata_i;
      end
      arr_we_o = (w_hs_a & a_we_i) | (w_hs_b & b_we_i);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
    end else if (cke_i) begin
      r_a_rvalid <= w_rd_a;
      r_b_rvalid <= w_rd_b;
      if (w_rd_a) begin
        r_a_rdata <= arr_d_i;
      end
      if (w_rd_b) begin
        r_b_rdata <= arr_d_i;
      end
    end
  end

  assign a_rvalid_o  = r_a_rvalid;
  assign a_rdata_o   = r_a_rdata;
  assign b_rvalid_o  = r_b_rvalid;
  assign b_rdata_o   = r_b_rdata;
  assign init_done_o = w_idle;

endmodule

// File: tb/tb_iob_regarray_sp_ctrl.sv
// Scoreboard bench for iob_regarray_sp_ctrl with a behavioural array and
// arbitration model; covers IOB_REGARRAY_SP_CTRL_INIT_EN on or off.
module tb_iob_regarray_sp_ctrl;

  localparam int       AW    = 3;
  localparam int       DW    = 8;
  localparam int       DEPTH = 1 << AW;
  localparam [DW-1:0]  IV    = 8'h5A;
`ifdef IOB_REGARRAY_SP_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          cke = 1'b1;
  logic          arst = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic          a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_d_o;
  logic [DW-1:0] arr_d_i;
  logic          init_done;

  iob_regarray_sp_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(IV)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .arr_we_o(arr_we), .arr_addr_o(arr_addr), .arr_d_o(arr_d_o), .arr_d_i(arr_d_i),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // The physical array the controller drives.
  logic [DW-1:0] arr_mem [DEPTH];
  always @(posedge clk) if (arr_we) arr_mem[arr_addr] <= arr_d_o;
  assign arr_d_i = arr_mem[arr_addr];

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  bit            m_last;   // 0 = A served last, 1 = B
  bit            m_idle;
  int            m_cnt;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check combinational outputs, update model.
  task automatic step(input bit c,
                      input bit av, input bit awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                      input bit bv, input bit bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                      output bit hsa, output bit hsb);
    bit ga, gb, ewe;
    @(negedge clk);
    cke = c;
    a_valid = av; a_we = awe; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = bad; b_wdata = bwd;
    #1;
    hsa = 1'b0; hsb = 1'b0;
    if (!m_idle) begin
      chk("init_ready_a", a_ready, 0);
      chk("init_ready_b", b_ready, 0);
      chk("init_done_low", init_done, 0);
      chk("init_we", arr_we, c);
      if (c) begin
        chk("init_addr", arr_addr, m_cnt);
        chk("init_data", arr_d_o, IV);
        ref_mem[m_cnt] = IV;
        m_cnt++;
        if (m_cnt == DEPTH) m_idle = 1'b1;
      end
    end else begin
      chk("init_done_high", init_done, 1);
      ga  = av && (!bv || m_last);
      gb  = bv && !ga;
      hsa = c && ga;
      hsb = c && gb;
      chk("ready_a", a_ready, hsa);
      chk("ready_b", b_ready, hsb);
      ewe = (hsa && awe) || (hsb && bwe);
      chk("arr_we", arr_we, ewe);
      if (ewe) begin
        chk("arr_addr", arr_addr, hsa ? aad : bad);
        chk("arr_d", arr_d_o, hsa ? awd : bwd);
      end
      if (hsa) begin
        if (awe) ref_mem[aad] = awd; else qa.push_back(ref_mem[aad]);
        m_last = 1'b0;
      end
      if (hsb) begin
        if (bwe) ref_mem[bad] = bwd; else qb.push_back(ref_mem[bad]);
        m_last = 1'b1;
      end
    end
  endtask

  // Called right after a step, so the reset lands before the next rising edge.
  task automatic do_reset();
    #1;
    arst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; cke = 1'b1;
    #1;
    chk("rst_ready_a", a_ready, 0);
    chk("rst_ready_b", b_ready, 0);
    chk("rst_rvalid_a", a_rvalid, 0);
    chk("rst_rvalid_b", b_rvalid, 0);
    chk("rst_rdata_a", a_rdata, 0);
    chk("rst_rdata_b", b_rdata, 0);
    chk("rst_init_done", init_done, !INIT_EN);
    qa.delete(); qb.delete();
    m_last = 1'b1; m_cnt = 0; m_idle = !INIT_EN;
    repeat (2) @(negedge clk);
    #2 arst = 1'b0;
  endtask

  // Response monitor: a pulse follows every read handshake by exactly one cke edge.
  bit            e_cke;
  logic          pa_rv = 1'b0, pb_rv = 1'b0;
  logic [DW-1:0] pa_d = '0, pb_d = '0;
  initial begin
    forever begin
      @(posedge clk);
      e_cke = cke && !arst;
      @(negedge clk);
      if (arst) begin
        pa_rv = 1'b0; pb_rv = 1'b0; pa_d = '0; pb_d = '0;
      end else begin
        if (e_cke) begin
          if (a_rvalid) begin
            if (qa.size() == 0) chk("a_spurious_rvalid", 1, 0);
            else begin pa_d = qa.pop_front(); chk("a_rdata", a_rdata, pa_d); end
          end else chk("a_rdata_hold", a_rdata, pa_d);
          if (b_rvalid) begin
            if (qb.size() == 0) chk("b_spurious_rvalid", 1, 0);
            else begin pb_d = qb.pop_front(); chk("b_rdata", b_rdata, pb_d); end
          end else chk("b_rdata_hold", b_rdata, pb_d);
          chk("a_lost_rvalid", qa.size(), 0);
          chk("b_lost_rvalid", qb.size(), 0);
        end else begin
          chk("a_rvalid_frozen", a_rvalid, pa_rv);
          chk("b_rvalid_frozen", b_rvalid, pb_rv);
          chk("a_rdata_frozen", a_rdata, pa_d);
          chk("b_rdata_frozen", b_rdata, pb_d);
        end
        pa_rv = a_rvalid; pb_rv = b_rvalid;
      end
    end
  end

  task automatic run_init();
    bit ha, hb;
    int guard = 0;
    while (!m_idle && guard < 100) begin
      step(($urandom % 4) != 0, $urandom % 2, 1'b0, AW'($urandom), '0,
           $urandom % 2, 1'b0, AW'($urandom), '0, ha, hb);
      guard++;
    end
    if (!m_idle) chk("init_sweep_timeout", 0, 1);
  endtask

  bit            ha, hb;
  bit            pa_v, pa_we, pb_v, pb_we;
  logic [AW-1:0] pa_ad, pb_ad;
  logic [DW-1:0] pa_wd, pb_wd;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin arr_mem[i] = '0; ref_mem[i] = '0; end
    m_last = 1'b1; m_cnt = 0; m_idle = !INIT_EN;
    @(negedge clk);
    do_reset();
    // Sweep with idle cycles, including a 3-cycle cke stall.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ha, hb);
    repeat (3) step(0, 1, 0, 1, 0, 0, 0, 0, 0, ha, hb);
    run_init();

    // Write then read back, plus an untouched address.
    step(1, 1, 1, 3, 8'hC4, 0, 0, 0, 0, ha, hb);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, ha, hb);
    step(1, 1, 0, 2, 0, 0, 0, 0, 0, ha, hb);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ha, hb);

    // Contention: grants must alternate.
    repeat (4) step(1, 1, 0, 1, 0, 1, 0, 2, 0, ha, hb);
    // B alone streams back-to-back.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, 0, AW'(i), 0, ha, hb);
    // Stall mid-stream with a held request, then resume.
    repeat (3) step(0, 1, 0, 5, 0, 1, 0, 6, 0, ha, hb);
    repeat (2) step(1, 1, 0, 5, 0, 1, 0, 6, 0, ha, hb);

    // Randomized traffic with valid/ready holding.
    pa_v = 0; pb_v = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa_v && ($urandom % 3) != 0) begin
        pa_v = 1; pa_we = $urandom % 2; pa_ad = AW'($urandom); pa_wd = DW'($urandom);
      end
      if (!pb_v && ($urandom % 3) != 0) begin
        pb_v = 1; pb_we = $urandom % 2; pb_ad = AW'($urandom); pb_wd = DW'($urandom);
      end
      step(($urandom % 8) != 0, pa_v, pa_we, pa_ad, pa_wd, pb_v, pb_we, pb_ad, pb_wd, ha, hb);
      if (ha) pa_v = 0;
      if (hb) pb_v = 0;
    end

    // Reset while a read is in flight: its response must be dropped.
    step(1, 1, 0, 4, 0, 0, 0, 0, 0, ha, hb);
    chk("pending_read_issued", ha, 1);
    do_reset();
    if (!INIT_EN) step(1, 1, 0, 3, 0, 0, 0, 0, 0, ha, hb);
    run_init();
    step(1, 1, 0, 0, 0, 1, 0, 7, 0, ha, hb);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, ha, hb);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iob_regarray_sp_ctrl.md
Name: iob_regarray_sp_ctrl

Overview:
Arbiter and sequencer that shares one single-port register array (we/addr/d_in/d_out, combinational read, registered write) between two requesters, A and B.
- Each requester has a valid/ready request channel and a read-response channel.
- Round-robin arbitration; at most one array access per cycle.
- Registered read data; optional post-reset clear sweep of the whole array.
- Sits between cache control logic and the tag/valid register arrays.

Parameters:
- ADDR_W, 3, array address width; array depth = 2**ADDR_W.
- DATA_W, 8, array word width.
- INIT_VAL, 0, word written to every entry by the init sweep (DATA_W bits).

Ports:
- clk_i  input  1  clock.
- cke_i  input  1  clock enable; low freezes all state.
- arst_i  input  1  reset, asynchronous, active-high.
- a_valid_i, b_valid_i  input  1  request valid.
- a_ready_o, b_ready_o  output  1  request accepted this cycle.
- a_we_i, b_we_i  input  1  1 = write, 0 = read.
- a_addr_i, b_addr_i  input  ADDR_W  request address.
- a_wdata_i, b_wdata_i  input  DATA_W  write data.
- a_rvalid_o, b_rvalid_o  output  1  read-data pulse.
- a_rdata_o, b_rdata_o  output  DATA_W  read data, held until the next read of that requester.
- arr_we_o  output  1  array write enable.
- arr_addr_o  output  ADDR_W  array address.
- arr_d_o  output  DATA_W  array write data.
- arr_d_i  input  DATA_W  array combinational read data.
- init_done_o  output  1  array ready for requests.

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-high on arst_i.
- Reset values: state INIT (macro on) or IDLE (macro off); all *_ready_o = 0; *_rvalid_o = 0; *_rdata_o = 0; last_grant = B, so A wins the first tie; init counter = 0; init_done_o = 0 (macro on) or 1 (macro off).
- FSM: INIT -> IDLE when the counter reaches 2**ADDR_W-1 and the write is issued. IDLE is terminal until reset.
- IDLE arbitration is combinational:
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on an accepted request.
- x_ready_o = grant_x & cke_i & (state == IDLE). A handshake is x_valid_i & x_ready_o.
- Array drive in IDLE:
  - arr_addr_o/arr_d_o come from the granted requester, else A's inputs.
  - arr_we_o = handshake & granted we.
- Read latency is 1 cycle. On a read handshake at edge t, arr_d_i is captured into x_rdata_o and x_rvalid_o = 1 during cycle t+1 for exactly one cycle.
- Writes produce no response.
- Throughput: one access per cycle. Back-to-back reads from the same requester give consecutive rvalid pulses.
- Write then read of the same address in the next cycle returns the new data, because the array updates on the write edge.
- Requests not granted must be held by the requester (valid/ready rules: valid held, payload stable until ready).
- cke_i low: no state changes, ready low, arr_we_o low, rvalid held at its registered value.
- arst_i mid-operation: pending response dropped; outputs return to reset values immediately; the init sweep restarts from address 0.

Optional Feature:
Macro: IOB_REGARRAY_SP_CTRL_INIT_EN.
- Defined:
  - Reset enters INIT; the counter sweeps addresses 0..2**ADDR_W-1, one per cke cycle, with arr_we_o = 1 and arr_d_o = INIT_VAL.
  - Ready stays low throughout the sweep.
  - init_done_o rises the cycle after the last write: 2**ADDR_W cke cycles after reset release.
- Undefined:
  - No INIT state and no counter; reset enters IDLE.
  - init_done_o is constant 1.
  - Array contents after reset are those given by the array's own reset.

Decomposition:
- Shared config include iob_regarray_sp_ctrl_conf.vh holds:
  - default ADDR_W, DATA_W, INIT_VAL;
  - localparams STATE_INIT = 1'b0, STATE_IDLE = 1'b1;
  - GRANT_A = 1'b0, GRANT_B = 1'b1.
- One natural sub-module: iob_regarray_sp_rr_arb2, a 2-input round-robin arbiter.
  - Inputs: valid pair, enable, accept.
  - Outputs: one-hot grant.
  - Owns the last_grant register.
- All state registers use the codebase register primitive with cke/arst.

Test Plan (ADDR_W=3, DATA_W=8, INIT_VAL=8'h5A, macro on unless stated):
1. Release reset, no requests -> arr_we_o high for 8 cycles on addresses 0..7 with data 5A; init_done_o = 1 on cycle 9; both ready low until then.
2. After init, A writes addr 3 = 8'hC4, then A reads addr 3 next cycle -> a_rvalid_o pulses one cycle later with a_rdata_o = C4; a read of addr 2 returns 5A.
3. A and B both valid for 4 cycles with reads of addr 1 and addr 2 -> grants alternate A, B, A, B; rvalid pulses alternate, with data matching each address.
4. B valid alone continuously while A is idle -> B granted every cycle; no lost or duplicated rvalid.
5. cke_i low for 3 cycles mid-stream, and separately during INIT -> no array writes, counter and FSM frozen, ready low; operation resumes exactly where it stopped.
6. arst_i pulsed while a read response is pending -> rvalid never asserts for it; init sweep restarts at addr 0. With macro off: init_done_o = 1 and A is ready in the first cycle after reset.
